// File: rtl/multi_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_branch_predictor_if
// Description : Fetch-side bundle of the branch predictor. Groups fetch
//               control (stall/flush/skip), the fetch PC, the resolved-branch
//               update port and the prediction result.
//               master : fetch/commit logic (drives fetch + update, reads pred)
//               slave  : the predictor itself
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_branch_predictor_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int GHR_WIDTH   = 8
);
    // fetch control
    logic                   stall;
    logic                   flush;
    logic                   skip;
    logic [31:0]            pc_cur;
    // resolved-branch update
    logic                   upd_valid;
    logic [31:0]            upd_pc;
    logic [31:0]            upd_target;
    logic [1:0]             upd_cf;
    logic                   upd_taken;
    logic [1:0]             upd_counter;
    logic [GHR_WIDTH-1:0]   upd_ghr;
    logic                   upd_mispredict;
    // prediction
    logic                   pred_valid;
    logic                   pred_taken;
    logic [31:0]            pred_target;
    logic [1:0]             pred_cf;
    logic [1:0]             pred_counter;
    logic [GHR_WIDTH-1:0]   pred_ghr;
    logic [FETCH_WIDTH-1:0] pred_sel;
    logic                   pred_wait_delayslot;

    modport master (
        output stall, flush, skip, pc_cur,
        output upd_valid, upd_pc, upd_target, upd_cf, upd_taken,
        output upd_counter, upd_ghr, upd_mispredict,
        input  pred_valid, pred_taken, pred_target, pred_cf, pred_counter,
        input  pred_ghr, pred_sel, pred_wait_delayslot
    );

    modport slave (
        input  stall, flush, skip, pc_cur,
        input  upd_valid, upd_pc, upd_target, upd_cf, upd_taken,
        input  upd_counter, upd_ghr, upd_mispredict,
        output pred_valid, pred_taken, pred_target, pred_cf, pred_counter,
        output pred_ghr, pred_sel, pred_wait_delayslot
    );
endinterface
`default_nettype wire

// File: rtl/multi_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : multi_branch_predictor
// Description : Multi-lane fetch-group branch predictor. Direct-mapped BTB
//               plus gshare BHT of 2-bit counters, looked up for every lane
//               of the fetch group in parallel; the first eligible BTB hit is
//               selected and presented one cycle after the fetch PC.
// Ports       : clk - clock (rising edge)
//               rst - synchronous reset, active low
//               bp  - multi_branch_predictor_if.slave (fetch control, fetch
//                     PC, update port, prediction outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_branch_predictor #(
    parameter int FETCH_WIDTH       = 2,
    parameter int ENTRIES           = 1024,
    parameter int GHR_WIDTH         = 8,
    parameter int ICACHE_LINE_WIDTH = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_branch_predictor_if.slave   bp
);
    localparam int         c_IDX        = $clog2(ENTRIES);
    localparam int         c_TAG_W      = 30 - c_IDX;
    localparam int         c_LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int         c_LINE_WORDS = ICACHE_LINE_WIDTH / 32;
    localparam logic [1:0] c_CF_NONE    = 2'd0;
    localparam logic [1:0] c_CF_BRANCH  = 2'd1;

    // ---------------- prediction tables ----------------
    logic [ENTRIES-1:0]   btb_valid_q;
    logic [c_TAG_W-1:0]   btb_tag_q [ENTRIES];
    logic [29:0]          btb_tgt_q [ENTRIES];
    logic [1:0]           btb_cf_q  [ENTRIES];
    logic [1:0]           bht_q     [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

    // ---------------- registered lookup results ----------------
    logic [FETCH_WIDTH-1:0]       hit_q, hit_d;
    logic [FETCH_WIDTH-1:0][29:0] tgt_q, tgt_d;
    logic [FETCH_WIDTH-1:0][1:0]  cf_q,  cf_d;
    logic [FETCH_WIDTH-1:0][1:0]  cnt_q, cnt_d;
    logic [29:0]                  base_q, base_d;   // word address of lane 0
    logic [GHR_WIDTH-1:0]         lk_ghr_q;
    logic                         flush_q;

    // group base and lane offset, both as word addresses
    logic [29:0] w_base_word, w_lane_off;
    assign w_base_word = bp.pc_cur[31:2] & ~30'(FETCH_WIDTH - 1);
    assign w_lane_off  = bp.pc_cur[31:2] &  30'(FETCH_WIDTH - 1);
    assign base_d      = w_base_word;

    // Tables are read combinationally from the pre-edge contents, so a
    // same-cycle update to the entry being looked up is not visible until
    // the next lookup.
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        logic [29:0]      w_word;
        logic [c_IDX-1:0] w_idx, w_bidx;
        assign w_word   = w_base_word + 30'(i);
        assign w_idx    = w_word[c_IDX-1:0];
        assign w_bidx   = w_idx ^ c_IDX'(ghr_q);
        // lanes before the fetch PC are not part of this fetch
        assign hit_d[i] = btb_valid_q[w_idx]
                       && (btb_tag_q[w_idx] == w_word[29:c_IDX])
                       && (btb_cf_q[w_idx] != c_CF_NONE)
                       && (30'(i) >= w_lane_off);
        assign tgt_d[i] = btb_tgt_q[w_idx];
        assign cf_d[i]  = btb_cf_q[w_idx];
        assign cnt_d[i] = bht_q[w_bidx];
    end

    always_ff @(posedge clk) begin
        if (!rst || bp.flush) begin
            hit_q    <= '0;
            tgt_q    <= '0;
            cf_q     <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            lk_ghr_q <= '0;
        end else if (!bp.stall) begin
            hit_q    <= hit_d;
            tgt_q    <= tgt_d;
            cf_q     <= cf_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            lk_ghr_q <= ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) flush_q <= 1'b0;
        else      flush_q <= bp.flush;
    end

    // ---------------- lane selection ----------------
    logic [c_LANE_W-1:0]    w_sel_idx;
    logic                   w_hit;
    logic [FETCH_WIDTH-1:0] w_sel;
    always_comb begin
        w_sel_idx = c_LANE_W'(FETCH_WIDTH - 1);
        w_hit     = 1'b0;
        // walk downwards so the lowest hitting lane wins
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                w_sel_idx = c_LANE_W'(i);
                w_hit     = 1'b1;
            end
        end
        w_sel = FETCH_WIDTH'(1) << w_sel_idx;
    end

    logic [29:0] w_sel_word;
    logic        w_last_word;
    logic        w_pred_valid, w_pred_taken;
    logic [1:0]  w_pred_cf;
    assign w_sel_word   = base_q + 30'(w_sel_idx);
    assign w_last_word  = (w_sel_word & 30'(c_LINE_WORDS - 1)) == 30'(c_LINE_WORDS - 1);
    assign w_pred_valid = w_hit && !bp.skip && !flush_q;
    assign w_pred_cf    = w_hit ? cf_q[w_sel_idx] : 2'd0;
    // non-branch control flow is always taken; a miss reports not-taken
    assign w_pred_taken = w_hit && ((cf_q[w_sel_idx] == c_CF_BRANCH) ? cnt_q[w_sel_idx][1] : 1'b1);

    assign bp.pred_valid          = w_pred_valid;
    assign bp.pred_taken          = w_pred_taken;
    assign bp.pred_cf             = w_pred_cf;
    assign bp.pred_target         = w_hit ? {tgt_q[w_sel_idx], 2'b00} : 32'h0;
    assign bp.pred_counter        = w_hit ? cnt_q[w_sel_idx] : 2'd0;
    assign bp.pred_ghr            = lk_ghr_q;
    assign bp.pred_sel            = w_sel;
    assign bp.pred_wait_delayslot = w_hit && w_last_word;

    // ---------------- global history ----------------
    always_comb begin
        ghr_d = ghr_q;
        // a resolved mispredict repairs history ahead of any speculative shift
        if (bp.upd_valid && bp.upd_mispredict) begin
            if (bp.upd_cf == c_CF_BRANCH) ghr_d = (bp.upd_ghr << 1) | GHR_WIDTH'(bp.upd_taken);
            else                          ghr_d = bp.upd_ghr;
        end else if (w_pred_valid && (w_pred_cf == c_CF_BRANCH) && !bp.stall) begin
            ghr_d = (ghr_q << 1) | GHR_WIDTH'(w_pred_taken);
        end
    end

    // ---------------- table update ----------------
    logic [c_IDX-1:0] w_upd_idx, w_upd_bidx;
    logic [1:0]       w_new_cnt;
    assign w_upd_idx  = bp.upd_pc[2 +: c_IDX];
    assign w_upd_bidx = w_upd_idx ^ c_IDX'(bp.upd_ghr);
    always_comb begin
        w_new_cnt = bp.upd_counter;
        if (bp.upd_taken) begin
            if (bp.upd_counter != 2'd3) w_new_cnt = bp.upd_counter + 2'd1;
        end else begin
            if (bp.upd_counter != 2'd0) w_new_cnt = bp.upd_counter - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid_q <= '0;
            for (int e = 0; e < ENTRIES; e++) bht_q[e] <= 2'b01;
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (bp.upd_valid) begin
                btb_valid_q[w_upd_idx] <= (bp.upd_cf != c_CF_NONE);
                btb_tag_q[w_upd_idx]   <= bp.upd_pc[31:2+c_IDX];
                btb_tgt_q[w_upd_idx]   <= bp.upd_target[31:2];
                btb_cf_q[w_upd_idx]    <= bp.upd_cf;
                if (bp.upd_cf == c_CF_BRANCH) bht_q[w_upd_bidx] <= w_new_cnt;
            end
        end
    end

    // byte-offset bits carry no information for word-aligned addresses
    logic w_unused;
    assign w_unused = &{1'b0, bp.pc_cur[1:0], bp.upd_pc[1:0], bp.upd_target[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_multi_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_branch_predictor
// Description : Directed, self-checking bench for multi_branch_predictor with
//               a table-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_branch_predictor;
    localparam int FW = 2, ENT = 1024, GW = 8, LW = 256;
    localparam int IDX = 10, LWORDS = LW / 32;
    localparam int unsigned GMASK = (1 << GW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_branch_predictor_if #(.FETCH_WIDTH(FW), .GHR_WIDTH(GW)) bpif ();
    multi_branch_predictor #(.FETCH_WIDTH(FW), .ENTRIES(ENT), .GHR_WIDTH(GW),
                             .ICACHE_LINE_WIDTH(LW))
        dut (.clk(clk), .rst(rst), .bp(bpif.slave));

    int nvec = 0;
    int nerr = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit          hit;
        int          sel;
        bit          taken;
        int unsigned target;
        int          cf;
        int          cnt;
        int unsigned ghr;
        bit          dly;
    } snap_t;

    bit          m_v   [ENT];
    int unsigned m_tag [ENT];
    int unsigned m_tgt [ENT];
    int          m_cf  [ENT];
    int          m_bht [ENT];
    int unsigned m_ghr;
    snap_t       snap, nsnap;
    bit          flush_prev;
    bit          started = 0;
    bit          m_pv;
    int unsigned m_idx;

    function automatic snap_t empty_snap();
        snap_t s;
        s = '{default: 0};
        s.sel = FW - 1;
        return s;
    endfunction

    function automatic snap_t lookup(int unsigned pc, int unsigned gh);
        snap_t s;
        int unsigned base, a, ix;
        s = empty_snap();
        s.ghr = gh;
        base = pc & ~(FW * 4 - 1);
        for (int l = int'((pc >> 2) % FW); l < FW; l++) begin
            a  = base + 4 * l;
            ix = (a >> 2) % ENT;
            if (m_v[ix] && m_tag[ix] == (a >> (2 + IDX)) && m_cf[ix] != 0) begin
                s.hit    = 1;
                s.sel    = l;
                s.cf     = m_cf[ix];
                s.target = m_tgt[ix];
                s.cnt    = m_bht[ix ^ gh];
                s.taken  = (s.cf == 1) ? (s.cnt >= 2) : 1'b1;
                s.dly    = ((a >> 2) % LWORDS) == LWORDS - 1;
                break;
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (!rst) begin
            for (int e = 0; e < ENT; e++) begin m_v[e] = 0; m_bht[e] = 1; end
            m_ghr      = 0;
            snap       = empty_snap();
            flush_prev = 0;
        end else begin
            m_pv  = snap.hit && !bpif.skip && !flush_prev;
            nsnap = lookup(bpif.pc_cur, m_ghr);
            if (bpif.upd_valid && bpif.upd_mispredict)
                m_ghr = (bpif.upd_cf == 1) ? (((int'(bpif.upd_ghr) << 1) | int'(bpif.upd_taken)) & GMASK)
                                           : bpif.upd_ghr;
            else if (m_pv && snap.cf == 1 && !bpif.stall)
                m_ghr = ((m_ghr << 1) | snap.taken) & GMASK;
            if (bpif.upd_valid) begin
                m_idx        = (bpif.upd_pc >> 2) % ENT;
                m_v[m_idx]   = (bpif.upd_cf != 0);
                m_tag[m_idx] = bpif.upd_pc >> (2 + IDX);
                m_tgt[m_idx] = bpif.upd_target & 32'hFFFF_FFFC;
                m_cf[m_idx]  = bpif.upd_cf;
                if (bpif.upd_cf == 1)
                    m_bht[m_idx ^ bpif.upd_ghr] = bpif.upd_taken ? ((bpif.upd_counter == 3) ? 3 : bpif.upd_counter + 1)
                                                                 : ((bpif.upd_counter == 0) ? 0 : bpif.upd_counter - 1);
            end
            if (bpif.flush)       snap = empty_snap();
            else if (!bpif.stall) snap = nsnap;
            flush_prev = bpif.flush;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the whole output bundle against the model mid-cycle, then
    // advance to just past the next rising edge.
    task automatic step();
        logic [48:0] e, a;
        bit pv;
        @(negedge clk);
        if (started) begin
            pv = snap.hit && !bpif.skip && !flush_prev;
            e  = {pv, snap.hit & snap.taken, snap.hit ? snap.target : 32'h0,
                  2'(snap.hit ? snap.cf : 0), 2'(snap.hit ? snap.cnt : 0),
                  8'(snap.ghr), 2'(1 << snap.sel), snap.hit & snap.dly};
            a  = {bpif.pred_valid, bpif.pred_taken, bpif.pred_target, bpif.pred_cf,
                  bpif.pred_counter, bpif.pred_ghr, bpif.pred_sel, bpif.pred_wait_delayslot};
            nvec++;
            if (a !== e) begin
                nerr++;
                $display("FAIL model @%0t: got %h expected %h", $time, a, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] cf,
                       input logic tk, input logic [1:0] cnt, input logic [7:0] gh, input logic mp);
        bpif.upd_valid      = 1'b1;
        bpif.upd_pc         = pc;
        bpif.upd_target     = tgt;
        bpif.upd_cf         = cf;
        bpif.upd_taken      = tk;
        bpif.upd_counter    = cnt;
        bpif.upd_ghr        = gh;
        bpif.upd_mispredict = mp;
    endtask

    task automatic noupd();
        bpif.upd_valid      = 1'b0;
        bpif.upd_mispredict = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        bpif.stall = 0; bpif.flush = 0; bpif.skip = 0;
        bpif.pc_cur = 32'h1000;
        upd(32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 8'h0, 1'b0);
        noupd();
        step(); step();
        chk("rst_valid",  32'(bpif.pred_valid),  32'd0);
        chk("rst_sel",    32'(bpif.pred_sel),    32'd2);
        chk("rst_target", bpif.pred_target,      32'd0);
        chk("rst_taken",  32'(bpif.pred_taken),  32'd0);
        chk("rst_ghr",    32'(bpif.pred_ghr),    32'd0);

        rst = 1'b1;
        step();
        chk("empty_valid", 32'(bpif.pred_valid), 32'd0);
        chk("empty_sel",   32'(bpif.pred_sel),   32'd2);

        // jump at 0x1004; the lookup in the write cycle sees the old entry
        upd(32'h1004, 32'h2000, 2'd3, 1'b1, 2'd0, 8'h00, 1'b0);
        step();
        chk("rdw_valid", 32'(bpif.pred_valid), 32'd0);
        noupd();
        step();
        chk("jmp_valid",  32'(bpif.pred_valid), 32'd1);
        chk("jmp_sel",    32'(bpif.pred_sel),   32'd2);
        chk("jmp_taken",  32'(bpif.pred_taken), 32'd1);
        chk("jmp_target", bpif.pred_target,     32'h2000);

        // branch at 0x1000 trained to counter 2
        upd(32'h1000, 32'h1800, 2'd1, 1'b1, 2'd1, 8'h00, 1'b0);
        step();
        noupd();
        bpif.pc_cur = 32'h1004;
        step();
        chk("off_sel", 32'(bpif.pred_sel), 32'd2);
        bpif.pc_cur = 32'h1000;
        step();
        chk("br_sel",   32'(bpif.pred_sel),     32'd1);
        chk("br_taken", 32'(bpif.pred_taken),   32'd1);
        chk("br_cnt",   32'(bpif.pred_counter), 32'd2);
        bpif.pc_cur = 32'h1004;
        step(); step();
        chk("ghr_shift", 32'(bpif.pred_ghr), 32'h01);

        bpif.skip = 1;
        step();
        chk("skip_valid", 32'(bpif.pred_valid), 32'd0);
        chk("skip_sel",   32'(bpif.pred_sel),   32'd2);
        bpif.skip = 0;

        // last word of the I-cache line, then stall and flush
        bpif.pc_cur = 32'h1018;
        upd(32'h101C, 32'h3000, 2'd3, 1'b1, 2'd0, 8'h00, 1'b0);
        step();
        noupd();
        step();
        chk("dly_slot",   32'(bpif.pred_wait_delayslot), 32'd1);
        chk("dly_target", bpif.pred_target,              32'h3000);
        bpif.stall  = 1;
        bpif.pc_cur = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_target", bpif.pred_target,              32'h3000);
            chk("stall_dly",    32'(bpif.pred_wait_delayslot), 32'd1);
        end
        bpif.stall = 0;
        bpif.flush = 1;
        step();
        chk("flush_valid", 32'(bpif.pred_valid), 32'd0);
        bpif.flush = 0;
        step();

        // history repair and counter saturation
        bpif.pc_cur = 32'h5000;
        upd(32'h1000, 32'h1800, 2'd1, 1'b1, 2'd3, 8'hA5, 1'b0);
        step();
        upd(32'h1004, 32'h2000, 2'd3, 1'b1, 2'd0, 8'hA5, 1'b1);
        step();
        noupd();
        bpif.pc_cur = 32'h1000;
        step();
        chk("ghr_load", 32'(bpif.pred_ghr),     32'hA5);
        chk("sat3_cnt", 32'(bpif.pred_counter), 32'd3);
        chk("sat3_tk",  32'(bpif.pred_taken),   32'd1);
        upd(32'h2010, 32'h2400, 2'd1, 1'b0, 2'd0, 8'h3C, 1'b1);
        bpif.pc_cur = 32'h5000;
        step();
        noupd();
        bpif.pc_cur = 32'h2010;
        step();
        chk("ghr_repair", 32'(bpif.pred_ghr), 32'h78);
        upd(32'h1004, 32'h2000, 2'd3, 1'b1, 2'd0, 8'h3C, 1'b1);
        bpif.pc_cur = 32'h5000;
        step();
        noupd();
        bpif.pc_cur = 32'h2010;
        step();
        chk("sat0_cnt", 32'(bpif.pred_counter), 32'd0);
        chk("sat0_ghr", 32'(bpif.pred_ghr),     32'h3C);

        // reset while an update is presented: the update must be lost
        rst = 1'b0;
        bpif.pc_cur = 32'h3000;
        upd(32'h3000, 32'h3400, 2'd3, 1'b1, 2'd0, 8'h00, 1'b0);
        step();
        chk("rst2_sel", 32'(bpif.pred_sel), 32'd2);
        chk("rst2_ghr", 32'(bpif.pred_ghr), 32'd0);
        rst = 1'b1;
        noupd();
        step();
        chk("discard_valid", 32'(bpif.pred_valid),  32'd0);
        chk("discard_target", bpif.pred_target,     32'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
